// File: rtl/pc_return_stack.sv
// Return-address stack beside the program counter: push on call, pop on return,
// with saturating count, empty/full status and sticky overflow/underflow flags.
module pc_return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             clear_err,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    // Low bits wrap 0 -> DEPTH-1 when the stack is full, which is the top slot.
    assign w_top_idx = r_count[PTR_W-1:0] - 1'b1;

    assign w_ovf_evt = push & ~pop & w_full;
    assign w_unf_evt = pop & w_empty;

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = '0;
        w_count_nxt = r_count;
        if (push && pop && !w_empty) begin
            // Tail-call replace: overwrite the top entry, depth unchanged.
            w_we    = 1'b1;
            w_waddr = w_top_idx;
        end else if (push && !w_full) begin
            w_we        = 1'b1;
            w_waddr     = r_count[PTR_W-1:0];
            w_count_nxt = r_count + 1'b1;
        end else if (pop && !push && !w_empty) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= push_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            // An error event in the same cycle as clear_err keeps the flag set.
            r_overflow  <= w_ovf_evt | (r_overflow  & ~clear_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clear_err);
        end
    end

    assign top       = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack: stimulus queues hand-computed expected
// state, a monitor pops and compares on each falling edge or async-reset probe.
module tb_pc_return_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_addr;
    logic             clear_err;
    logic [WIDTH-1:0] top;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    typedef struct {
        logic [WIDTH-1:0] top;
        logic [PTR_W:0]   cnt;
        logic             ovf;
        logic             unf;
        string            name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event chk_async;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .clear_err (clear_err),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, string fld, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: actual=0x%0h required=0x%0h (t=%0t)", nm, fld, act, req, $time);
        end
    endtask

    // Monitor: compare outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_async);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "top",       int'(top),       int'(e.top));
                chk(e.name, "count",     int'(count),     int'(e.cnt));
                chk(e.name, "empty",     int'(empty),     int'(e.cnt == 0));
                chk(e.name, "full",      int'(full),      int'(e.cnt == DEPTH));
                chk(e.name, "overflow",  int'(overflow),  int'(e.ovf));
                chk(e.name, "underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    task automatic expect_state(string nm, logic [WIDTH-1:0] t, int c, logic o, logic u);
        exp_t e;
        e.top  = t;
        e.cnt  = (PTR_W+1)'(c);
        e.ovf  = o;
        e.unf  = u;
        e.name = nm;
        q.push_back(e);
    endtask

    // One clocked operation; expected values describe state after the next rising edge.
    task automatic step(string nm, logic pu, logic po, logic [WIDTH-1:0] a, logic clr,
                        logic [WIDTH-1:0] t, int c, logic o, logic u);
        @(negedge clk);
        #1;
        push      = pu;
        pop       = po;
        push_addr = a;
        clear_err = clr;
        expect_state(nm, t, c, o, u);
    endtask

    // Assert reset between edges and check it took effect before any rising edge.
    task automatic async_reset(string nm);
        @(negedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        #2;
        expect_state(nm, '0, 0, 1'b0, 1'b0);
        ->chk_async;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = '0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;

        // 1: idle after reset
        step("idle", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);

        // 2: push three, pop three
        step("push10", 1, 0, 16'h0010, 0, 16'h0010, 1, 0, 0);
        step("push20", 1, 0, 16'h0020, 0, 16'h0020, 2, 0, 0);
        step("push30", 1, 0, 16'h0030, 0, 16'h0030, 3, 0, 0);
        step("pop1",   0, 1, 16'h0000, 0, 16'h0020, 2, 0, 0);
        step("pop2",   0, 1, 16'h0000, 0, 16'h0010, 1, 0, 0);
        step("pop3",   0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);

        // 3: fill to DEPTH, then one refused push
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1, 0, 16'(16'h0100 + i), 0, 16'(16'h0100 + i), i + 1, 0, 0);
        step("push_full", 1, 0, 16'hBEEF, 0, 16'h0107, 8, 1, 0);
        for (int i = 0; i < DEPTH; i++)
            step("drain", 0, 1, 16'h0000, 0, (i < 7) ? 16'(16'h0106 - i) : 16'h0000, 7 - i, 1, 0);
        step("clr_ovf", 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);

        // 4: underflow sticky / clear / clear-vs-event
        step("pop_empty", 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 1);
        step("hold_unf",  0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
        step("clr_unf",   0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        step("clr_and_pop", 0, 1, 16'h0000, 1, 16'h0000, 0, 0, 1);
        step("clr_unf2",  0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);

        // 5: tail-call replace, and push&pop on empty
        step("push41",   1, 0, 16'h0041, 0, 16'h0041, 1, 0, 0);
        step("push42",   1, 0, 16'h0042, 0, 16'h0042, 2, 0, 0);
        step("replace99",1, 1, 16'h0099, 0, 16'h0099, 2, 0, 0);
        step("pop_r1",   0, 1, 16'h0000, 0, 16'h0041, 1, 0, 0);
        step("pop_r2",   0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
        step("pp_empty", 1, 1, 16'h0077, 0, 16'h0077, 1, 0, 1);
        step("clr_push", 1, 0, 16'h0200, 1, 16'h0200, 2, 0, 0);
        for (int i = 1; i < 7; i++)
            step("refill", 1, 0, 16'(16'h0200 + i), 0, 16'(16'h0200 + i), i + 2, 0, 0);
        step("replace_full", 1, 1, 16'hAAAA, 0, 16'hAAAA, 8, 0, 0);
        step("pop_after_rep", 0, 1, 16'h0000, 0, 16'h0205, 7, 0, 0);

        // 6: asynchronous reset mid-operation
        async_reset("areset_a");
        step("push1234", 1, 0, 16'h1234, 0, 16'h1234, 1, 0, 0);
        step("push5678", 1, 0, 16'h5678, 0, 16'h5678, 2, 0, 0);
        async_reset("areset_b");
        step("push0001", 1, 0, 16'h0001, 0, 16'h0001, 1, 0, 0);
        step("idle_end", 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0 pending", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
